// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS  = 4;
    localparam int KP_COLS  = 4;
    localparam int DB_CNT_W = 3;

    function automatic int kp_clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int KEY_W = kp_clog2_min1(KP_ROWS * KP_COLS);

    // is_release: 0 = press, 1 = release ("release" itself is a reserved word)
    typedef struct packed {
        logic             is_release;
        logic [KEY_W-1:0] code;
    } kp_event_t;

endpackage

// File: rtl/kp_event_fifo.sv
// Event FIFO with a registered head entry; full-with-pop accepts a push.
module kp_event_fifo
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  kp_event_t push_data,
    input  logic      pop,
    output kp_event_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = kp_clog2_min1(FIFO_DEPTH);
    localparam int CW = AW + 1;

    kp_event_t     mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic          do_push;
    logic          do_pop;

    assign empty           = (count == '0);
    assign full            = (count == CW'(FIFO_DEPTH));
    assign do_pop          = pop & ~empty;
    assign do_push         = push & (~full | do_pop);
    assign rd_next         = rd_ptr + AW'(do_pop);
    assign count_after_pop = count - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count  <= count_after_pop + CW'(do_push);
            // A push into an otherwise empty FIFO becomes the head directly.
            if (do_push && (count_after_pop == '0)) begin
                head <= push_data;
            end else if (do_pop) begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobing, per-key debounce and press/release event FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_en,
    input  logic [N_ROWS-1:0] row,
    output logic [N_COLS-1:0] col,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_release,
    output logic              overflow
);

    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int CIW    = kp_clog2_min1(N_COLS);
    localparam int DW     = kp_clog2_min1(SETTLE_CYCLES + 1);
    localparam int RW     = kp_clog2_min1(N_ROWS);

    generate
        if (N_ROWS < 1 || N_COLS < 2) begin : g_bad_matrix
            $error("keypad_scanner: need N_ROWS >= 1 and N_COLS >= 2");
        end
        if (SETTLE_CYCLES < N_ROWS - 1) begin : g_bad_settle
            $error("keypad_scanner: SETTLE_CYCLES must be >= N_ROWS-1");
        end
        if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 7) begin : g_bad_debounce
            $error("keypad_scanner: DEBOUNCE_SCANS must be 1..7");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("keypad_scanner: FIFO_DEPTH must be a power of 2, >= 2");
        end
        if (kp_clog2_min1(N_KEYS) > KEY_W) begin : g_bad_keyw
            $error("keypad_scanner: key index does not fit keypad_pkg::KEY_W");
        end
    endgenerate

    logic [CIW-1:0]      col_idx;
    logic [DW-1:0]       dwell;
    logic                sample;

    logic [N_KEYS-1:0]   state;
    logic [N_KEYS-1:0]   state_n;
    logic [DB_CNT_W-1:0] db_cnt [N_KEYS];
    logic [DB_CNT_W-1:0] cnt_n  [N_KEYS];

    logic [N_ROWS-1:0]   pend;
    logic [N_ROWS-1:0]   pend_rel;
    logic [CIW-1:0]      pend_col;
    logic [N_ROWS-1:0]   new_pend;
    logic [N_ROWS-1:0]   new_rel;
    logic [N_ROWS-1:0]   drain_mask;
    logic [RW-1:0]       sel;

    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;
    kp_event_t           push_data;
    kp_event_t           head;

    assign sample = scan_en && (dwell == DW'(SETTLE_CYCLES));

    always_comb begin
        col          = '0;
        col[col_idx] = 1'b1;
    end

    // Debounce only the keys of the column being sampled this cycle.
    always_comb begin
        state_n  = state;
        cnt_n    = db_cnt;
        new_pend = '0;
        new_rel  = '0;
        if (sample) begin
            for (int r = 0; r < N_ROWS; r++) begin
                if (row[r] != state[int'(col_idx) * N_ROWS + r]) begin
                    if (db_cnt[int'(col_idx) * N_ROWS + r] == DB_CNT_W'(DEBOUNCE_SCANS - 1)) begin
                        state_n[int'(col_idx) * N_ROWS + r] = row[r];
                        cnt_n[int'(col_idx) * N_ROWS + r]   = '0;
                        new_pend[r]                         = 1'b1;
                        new_rel[r]                          = ~row[r];
                    end else begin
                        cnt_n[int'(col_idx) * N_ROWS + r] = db_cnt[int'(col_idx) * N_ROWS + r] + 1'b1;
                    end
                end else begin
                    cnt_n[int'(col_idx) * N_ROWS + r] = '0;
                end
            end
        end
    end

    // Lowest pending row drains first, one per cycle.
    always_comb begin
        sel = '0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (pend[r]) begin
                sel = RW'(r);
            end
        end
        push                 = |pend;
        drain_mask           = '0;
        drain_mask[sel]      = push;
        push_data.is_release = pend_rel[sel];
        push_data.code       = KEY_W'(int'(pend_col) * N_ROWS + int'(sel));
    end

    assign pop  = key_valid & key_ready;
    assign drop = push & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_idx  <= '0;
            dwell    <= '0;
            state    <= '0;
            pend     <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < N_KEYS; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            if (sample) begin
                dwell   <= '0;
                col_idx <= (col_idx == CIW'(N_COLS - 1)) ? '0 : col_idx + 1'b1;
            end else if (scan_en) begin
                dwell <= dwell + 1'b1;
            end
            state  <= state_n;
            db_cnt <= cnt_n;
            // The last drain of the previous column may coincide with this sample.
            pend   <= sample ? new_pend : (pend & ~drain_mask);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sample) begin
            pend_col <= col_idx;
            pend_rel <= new_rel;
        end
    end

    kp_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_valid   = ~fifo_empty;
    assign key_code    = head.code;
    assign key_release = head.is_release;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
    import keypad_pkg::*;

    typedef struct packed {
        logic       rel;
        logic [3:0] code;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             scan_en;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_code;
    logic             key_release;
    logic             overflow;
    logic [15:0]      keys;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  n_events = 0;

    always #5 clk = ~clk;

    keypad_scanner dut (
        .clk         (clk),
        .reset       (reset),
        .scan_en     (scan_en),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_release (key_release),
        .overflow    (overflow)
    );

    // Physical matrix: a pressed key connects its column strobe to its row line.
    always_comb begin
        row = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col[c] && keys[c * 4 + r]) row[r] = 1'b1;
            end
        end
    end

    // Every accepted transfer is checked against the scoreboard.
    always @(negedge clk) begin
        if (key_valid === 1'b1 && key_ready === 1'b1) begin
            n_events++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got rel=%0b code=%0d, required no event", key_release, key_code);
            end else begin
                mon_e = exp_q.pop_front();
                if ({key_release, key_code} !== {mon_e.rel, mon_e.code}) begin
                    n_bad++;
                    $display("FAIL event_value: got rel=%0b code=%0d, required rel=%0b code=%0d",
                             key_release, key_code, mon_e.rel, mon_e.code);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic rel, input int code);
        ev_t e;
        e.rel  = rel;
        e.code = code[3:0];
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected events still outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_pending(input string name, input int want);
        n_cmp++;
        if (exp_q.size() != want) begin
            n_bad++;
            $display("FAIL %s: %0d events outstanding, required %0d", name, exp_q.size(), want);
        end
    endtask

    // Leaves the bench one step after the edge that selected column 0 (dwell 0).
    task automatic align_col0();
        int g = 0;
        while (col !== 4'b1000 && g < 80) begin tick(1); g++; end
        while (col !== 4'b0001 && g < 80) begin tick(1); g++; end
        n_cmp++;
        if (g >= 80) begin
            n_bad++;
            $display("FAIL align_timeout: col=%b after %0d cycles, required 0001", col, g);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({col, key_valid, overflow, key_code, key_release} !== {4'b0001, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: col=%b valid=%b ovf=%b code=%0d rel=%b, required 0001 0 0 0 0",
                     name, col, key_valid, overflow, key_code, key_release);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; scan_en = 1'b1; key_ready = 1'b1; keys = '0;
        tick(2);
        reset = 1'b0;
        check_reset_outputs("reset_state");
        tick(3);
        n_cmp++;
        if (col !== 4'b0001) begin n_bad++; $display("FAIL dwell_hold: col=%b, required 0001", col); end
        tick(1);
        n_cmp++;
        if (col !== 4'b0010) begin n_bad++; $display("FAIL col_advance: col=%b, required 0010", col); end
    endtask

    task automatic test_single_press();
        int ev0 = n_events;
        keys[6] = 1'b1;
        push_exp(1'b0, 6);
        tick(32);
        check_pending("press6_early", 1);
        tick(48);
        check_drained("press6");
        n_cmp++;
        if (n_events - ev0 != 1) begin n_bad++; $display("FAIL press6_count: got %0d events, required 1", n_events - ev0); end
        keys[6] = 1'b0;
        push_exp(1'b1, 6);
        tick(32);
        check_pending("release6_early", 1);
        tick(48);
        check_drained("release6");
    endtask

    task automatic test_bounce();
        int ev0 = n_events;
        repeat (3) begin
            keys[9] = 1'b1; tick(32);
            keys[9] = 1'b0; tick(16);
        end
        tick(64);
        n_cmp++;
        if (n_events != ev0) begin n_bad++; $display("FAIL bounce9: got %0d events, required 0", n_events - ev0); end
    endtask

    task automatic test_two_keys();
        int ev0;
        align_col0();
        ev0 = n_events;
        keys[3] = 1'b1; keys[12] = 1'b1;
        push_exp(1'b0, 3); push_exp(1'b0, 12);
        tick(64);
        check_drained("press3_12");
        n_cmp++;
        if (n_events - ev0 != 2) begin n_bad++; $display("FAIL press3_12_count: got %0d, required 2", n_events - ev0); end
        keys[12] = 1'b0;
        push_exp(1'b1, 12);
        tick(64);
        check_drained("release12");
        keys[3] = 1'b0;
        push_exp(1'b1, 3);
        tick(64);
        check_drained("release3");
    endtask

    task automatic test_overflow();
        int unstable = 0;
        key_ready = 1'b0;
        align_col0();
        keys[4:0] = 5'h1f;
        for (int k = 0; k < 4; k++) push_exp(1'b0, k);
        for (int i = 1; i <= 64; i++) begin
            tick(1);
            if (i == 36) begin
                n_cmp++;
                if (key_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid: valid=%b, required 0", key_valid); end
            end
            if (i == 37) begin
                n_cmp++;
                if (key_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: valid=%b, required 1", key_valid); end
            end
            if (i == 40) begin
                n_cmp++;
                if (overflow !== 1'b0) begin n_bad++; $display("FAIL early_overflow: ovf=%b, required 0", overflow); end
            end
            if (i == 41) begin
                n_cmp++;
                if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_set: ovf=%b, required 1", overflow); end
            end
            if (key_valid === 1'b1 && {key_code, key_release} !== 5'b0) unstable++;
        end
        n_cmp++;
        if (unstable != 0) begin n_bad++; $display("FAIL head_stable: %0d cycles with head != code 0 press, required 0", unstable); end
        key_ready = 1'b1;
        tick(12);
        check_drained("drain0_3");
        n_cmp++;
        if ({overflow, key_valid} !== 2'b10) begin
            n_bad++; $display("FAIL after_drain: ovf=%b valid=%b, required 1 0", overflow, key_valid);
        end
        align_col0();
        keys[4:0] = 5'h00;
        for (int k = 0; k < 5; k++) push_exp(1'b1, k);
        tick(64);
        check_drained("release0_4");
    endtask

    task automatic test_reset_mid();
        keys[5] = 1'b1;
        push_exp(1'b0, 5);
        tick(64);
        check_drained("press5");
        tick(5);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check_reset_outputs("reset_mid");
        push_exp(1'b0, 5);
        tick(32);
        check_pending("repress5_early", 1);
        tick(48);
        check_drained("repress5");
        keys[5] = 1'b0;
        push_exp(1'b1, 5);
        tick(64);
        check_drained("release5");
    endtask

    task automatic test_scan_freeze();
        logic [3:0] c0;
        int moved = 0;
        int ev0   = n_events;
        c0 = col;
        scan_en = 1'b0;
        keys[10] = 1'b1;
        repeat (40) begin
            tick(1);
            if (col !== c0) moved++;
        end
        n_cmp++;
        if (moved != 0 || n_events != ev0) begin
            n_bad++; $display("FAIL freeze: col moved %0d cycles, %0d events, required 0 0", moved, n_events - ev0);
        end
        scan_en = 1'b1;
        push_exp(1'b0, 10);
        tick(4);
        n_cmp++;
        if (col === c0) begin n_bad++; $display("FAIL unfreeze: col=%b, required change from %b", col, c0); end
        tick(60);
        check_drained("press10");
        keys[10] = 1'b0;
        push_exp(1'b1, 10);
        tick(64);
        check_drained("release10");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_overflow();
        test_reset_mid();
        test_scan_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
